axi_gran_burst_splitter_w_chan: RTL and testbench
=================================================

# axi_gran_burst_splitter_w_chan

W-channel stage of the granular burst splitter, sitting downstream of the Ax-channel splitting stage on the write path. It records the length of every split AW burst that leaves the splitter in an in-order length queue. It forwards upstream W beats unchanged except for `last`, which it regenerates so that every split AW burst receives exactly `len+1` beats terminated by `last`. Optionally, it checks that upstream `last` coincides with the end of the final split piece of each original burst.

## Interface
Parameters:
- `w_chan_t`, `logic`: AXI W channel struct; must contain field `last`.
- `MaxTxns`, `32'd0`: length-queue depth, i.e. split AW bursts outstanding without W completion; must be ≥ 1 (elaboration assertion).

Ports:
- Clock and reset are fixed: one clock, `clk_i`; reset `rst_ni` is asynchronous and active-low.
- `clk_i`  in  1  clock
- `rst_ni`  in  1  async active-low reset
- `len_i`  in  `axi_pkg::len_t`  AXI len of one emitted split AW burst
- `len_final_i`  in  1  high if this piece is the last piece of its original burst
- `len_valid_i`  in  1  split AW handshake observed (AW valid & ready downstream of splitter)
- `len_ready_o`  out  1  queue not full; top level gates AW ready with it
- `w_i`  in  `w_chan_t`  upstream W beat
- `w_valid_i`  in  1  upstream valid
- `w_ready_o`  out  1  upstream ready
- `w_o`  out  `w_chan_t`  downstream W beat, `last` regenerated
- `w_valid_o`  out  1  downstream valid
- `w_ready_i`  in  1  downstream ready
- `err_o`  out  1  sticky `last`-mismatch flag

## Operation
- Length queue: FIFO of `{final, len}`, depth `MaxTxns`. Push on `len_valid_i && len_ready_o`. `len_ready_o = !full`.
- Beat counter `beat_q` (`axi_pkg::len_t`) counts handshaken beats of the head burst.
- Forwarding is gated on a non-empty queue:
  - `w_valid_o = w_valid_i && !empty`
  - `w_ready_o = w_ready_i && !empty`
  - `w_o = w_i`, except `w_o.last = (beat_q == head.len)`
- On a downstream handshake:
  - if `w_o.last`: pop the queue and clear `beat_q` to 0;
  - otherwise: increment `beat_q`.
- W beats that arrive before their AW are stalled, not dropped.
- `head.len == 0`: every beat is last; pop on each beat.
- `head.len == 255`: `beat_q` reaches 255 without overflow, then clears to 0.

## Timing
- W path is combinational: zero latency from `w_i` to `w_o`, no bubbles between bursts.
- Length queue is not fall-through. An entry pushed in cycle t can first govern a beat in cycle t+1. With an empty queue, `w_valid_o` stays 0 in cycle t.
- Full queue with a pop in the same cycle: `len_ready_o` stays 0 that cycle; the freed slot is usable from t+1.
- Empty queue: no pop is possible; a push lands normally.
- Reset values: FIFO empty, `beat_q = 0`, `err_o = 0`. Hence `len_ready_o = 1`, `w_valid_o = 0`, `w_ready_o = 0`.
- Reset asserted mid-burst discards all queued lengths and the partial count. No recovery of in-flight beats.

## Configuration
- Macro: `AXI_GRAN_W_LAST_CHECK_EN`.
- Defined:
  - The `final` bit is stored per queue entry.
  - On each downstream handshake, a mismatch sets `err_o`, which stays high until reset. A mismatch is either: `w_i.last` is 1 when `!(w_o.last && head.final)`, or `w_i.last` is 0 when `w_o.last && head.final`.
  - The beat is still forwarded with regenerated `last`.
- Undefined:
  - `len_final_i` is ignored and not stored (queue width = `LenWidth`).
  - `err_o` is tied to 0.

## Structure
- The queue-entry typedef `{logic final; axi_pkg::len_t len;}` goes in the shared splitter package next to the other splitter types.
- Sub-module: `fifo_v3` from common_cells (`FALL_THROUGH = 0`, `DEPTH = MaxTxns`) for the length queue.
- Beat counter and `err_o` use `FFARN` registers.

## Test plan
- Pieces len 3, 3, 1 (final on the third), then 10 W beats with upstream last on beat 10 → `w_o.last` on beats 4, 8, 10. Queue ends empty, `err_o = 0`.
- W valid held high for 5 cycles before any AW push → `w_valid_o = 0`, `w_ready_o = 0`. Push len 0 at cycle 6 → first beat passes at cycle 7 with `last = 1`.
- `MaxTxns = 2`, push 2 lengths, keep `w_ready_i = 0` → `len_ready_o = 0`. Complete first burst → `len_ready_o = 1` the cycle after the pop.
- Single piece len 255 → 256 beats, last only on beat 256, `beat_q` returns to 0.
- With `AXI_GRAN_W_LAST_CHECK_EN`: len 3 final, upstream last on beat 2 → `err_o` rises the cycle after beat 2 and stays high; beat 4 still carries `w_o.last`.
- Assert `rst_ni` after 2 of 4 beats → after release, queue empty, `err_o = 0`; a new len 1 burst completes with last on beat 2.

Source files
------------

// File: rtl/axi_gran_burst_splitter_w_chan_pkg.sv
// rtl/axi_gran_burst_splitter_w_chan_pkg.sv - shared types for the granular burst splitter W-channel stage
package axi_gran_burst_splitter_w_chan_pkg;

    localparam int unsigned LenWidth  = 8;
    localparam int unsigned DataWidth = 32;

    typedef logic [LenWidth-1:0] len_t;

    // One length-queue entry per emitted split AW burst.
    typedef struct packed {
        logic is_final;
        len_t len;
    } len_entry_t;

    typedef struct packed {
        logic [DataWidth-1:0]   data;
        logic [DataWidth/8-1:0] strb;
        logic                   last;
    } w_beat_t;

    function automatic int unsigned ptr_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/axi_gran_burst_splitter_w_chan_fifo.sv
// rtl/axi_gran_burst_splitter_w_chan_fifo.sv - registered-output length queue (no fall-through)
module axi_gran_burst_splitter_w_chan_fifo
    import axi_gran_burst_splitter_w_chan_pkg::*;
#(
    parameter bit          FALL_THROUGH = 1'b0,
    parameter int unsigned DEPTH        = 1,
    parameter int unsigned DATA_WIDTH   = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  push_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  pop_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  full_o,
    output logic                  empty_o
);

    localparam int unsigned PtrW  = ptr_width(DEPTH);
    localparam int unsigned CntW  = ptr_width(DEPTH + 1);
    localparam int unsigned Slots = (DEPTH > 0) ? DEPTH : 1;

    if (FALL_THROUGH) begin : g_fall_through_check
        $fatal(1, "length queue supports FALL_THROUGH = 0 only");
    end

    logic [DATA_WIDTH-1:0] mem_q [Slots];
    logic [PtrW-1:0]       wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]       cnt_q;
    logic                  do_push, do_pop;

    function automatic logic [PtrW-1:0] inc_ptr(input logic [PtrW-1:0] ptr);
        return (ptr == PtrW'(DEPTH - 1)) ? '0 : ptr + PtrW'(1);
    endfunction

    assign full_o  = (cnt_q == CntW'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign data_o  = mem_q[rd_ptr_q];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= inc_ptr(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_q <= inc_ptr(rd_ptr_q);
            end
            if (do_push && !do_pop) begin
                cnt_q <= cnt_q + CntW'(1);
            end else if (!do_push && do_pop) begin
                cnt_q <= cnt_q - CntW'(1);
            end
        end
    end

    // Payload storage needs no reset: occupancy is tracked by cnt_q.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/axi_gran_burst_splitter_w_chan.sv
// rtl/axi_gran_burst_splitter_w_chan.sv - W-channel last regeneration for split AW bursts; optional check via AXI_GRAN_W_LAST_CHECK_EN
module axi_gran_burst_splitter_w_chan
    import axi_gran_burst_splitter_w_chan_pkg::*;
#(
    parameter type         w_chan_t = w_beat_t,
    parameter int unsigned MaxTxns  = 32'd0
) (
    input  logic    clk_i,
    input  logic    rst_ni,
    input  len_t    len_i,
    input  logic    len_final_i,
    input  logic    len_valid_i,
    output logic    len_ready_o,
    input  w_chan_t w_i,
    input  logic    w_valid_i,
    output logic    w_ready_o,
    output w_chan_t w_o,
    output logic    w_valid_o,
    input  logic    w_ready_i,
    output logic    err_o
);

    if (MaxTxns < 32'd1) begin : g_max_txns_check
        $fatal(1, "MaxTxns must be at least 1");
    end

`ifdef AXI_GRAN_W_LAST_CHECK_EN
    localparam int unsigned EntryW = $bits(len_entry_t);
`else
    localparam int unsigned EntryW = LenWidth;
`endif

    logic [EntryW-1:0] push_entry, head_entry;
    logic              q_full, q_empty, q_pop;
    len_t              head_len;
    len_t              beat_q;
    logic              last_beat, w_hs;

`ifdef AXI_GRAN_W_LAST_CHECK_EN
    len_entry_t head_fields;
    logic       err_q;

    assign push_entry  = len_entry_t'{is_final: len_final_i, len: len_i};
    assign head_fields = len_entry_t'(head_entry);
    assign head_len    = head_fields.len;
`else
    logic unused_len_final;

    assign unused_len_final = len_final_i;
    assign push_entry       = len_i;
    assign head_len         = head_entry;
`endif

    axi_gran_burst_splitter_w_chan_fifo #(
        .FALL_THROUGH (1'b0),
        .DEPTH        (MaxTxns),
        .DATA_WIDTH   (EntryW)
    ) i_len_queue (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (len_valid_i),
        .data_i  (push_entry),
        .pop_i   (q_pop),
        .data_o  (head_entry),
        .full_o  (q_full),
        .empty_o (q_empty)
    );

    assign len_ready_o = !q_full;

    // Beats with no recorded AW burst stall upstream rather than being dropped.
    assign w_valid_o = w_valid_i && !q_empty;
    assign w_ready_o = w_ready_i && !q_empty;
    assign w_hs      = w_valid_i && w_ready_i && !q_empty;
    assign last_beat = (beat_q == head_len);
    assign q_pop     = w_hs && last_beat;

    always_comb begin
        w_o      = w_i;
        w_o.last = last_beat;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            beat_q <= '0;
        end else if (w_hs) begin
            beat_q <= last_beat ? '0 : beat_q + len_t'(1);
        end
    end

`ifdef AXI_GRAN_W_LAST_CHECK_EN
    // Upstream last must land exactly on the end of the original burst's final piece.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_q <= 1'b0;
        end else if (w_hs && (w_i.last != (last_beat && head_fields.is_final))) begin
            err_q <= 1'b1;
        end
    end

    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_axi_gran_burst_splitter_w_chan.sv
// tb/tb_axi_gran_burst_splitter_w_chan.sv - randomized self-checking bench against a beat-list reference model
module tb_axi_gran_burst_splitter_w_chan;
    import axi_gran_burst_splitter_w_chan_pkg::*;

    localparam int unsigned MAX = 2;
`ifdef AXI_GRAN_W_LAST_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic    clk = 1'b0;
    logic    rst_ni = 1'b0;
    len_t    len_i = '0;
    logic    len_final_i = 1'b0;
    logic    len_valid_i = 1'b0;
    logic    len_ready_o;
    w_beat_t w_i = '0;
    logic    w_valid_i = 1'b0;
    logic    w_ready_o;
    w_beat_t w_o;
    logic    w_valid_o;
    logic    w_ready_i = 1'b0;
    logic    err_o;

    axi_gran_burst_splitter_w_chan #(
        .MaxTxns (MAX)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_ni),
        .len_i       (len_i),
        .len_final_i (len_final_i),
        .len_valid_i (len_valid_i),
        .len_ready_o (len_ready_o),
        .w_i         (w_i),
        .w_valid_i   (w_valid_i),
        .w_ready_o   (w_ready_o),
        .w_o         (w_o),
        .w_valid_o   (w_valid_o),
        .w_ready_i   (w_ready_i),
        .err_o       (err_o)
    );

    always #5 clk = ~clk;

    // Reference model: every accepted burst is expanded into its beat list.
    bit exp_last[$];
    bit exp_fin[$];
    int n_out = 0;
    bit err_m = 1'b0;
    int n_checks = 0;
    int n_pass = 0;

    typedef struct {
        int unsigned len;
        bit          fin;
    } aw_t;

    aw_t aw_todo[$];
    bit  w_todo[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step(input bit push, input int unsigned len, input bit fin,
                        input bit wv, input bit wl, input bit wr,
                        output bit pushed, output bit beat);
        logic [31:0] d;
        bit el, ef;
        d           = $urandom;
        len_valid_i = push;
        len_i       = len_t'(len);
        len_final_i = fin;
        w_valid_i   = wv;
        w_i.data    = d;
        w_i.strb    = 4'($urandom);
        w_i.last    = wl;
        w_ready_i   = wr;
        @(negedge clk);
        check("len_ready", 32'(len_ready_o), 32'(n_out < MAX));
        check("w_valid", 32'(w_valid_o), 32'(wv && n_out > 0));
        check("w_ready", 32'(w_ready_o), 32'(wr && n_out > 0));
        check("err", 32'(err_o), 32'(err_m));
        pushed = push && (n_out < MAX);
        beat   = wv && wr && (n_out > 0);
        if (beat) begin
            el = exp_last.pop_front();
            ef = exp_fin.pop_front();
            check("w_last", 32'(w_o.last), 32'(el));
            check("w_data", w_o.data, d);
            if (CHK && (wl != (el && ef))) err_m = 1'b1;
            if (el) n_out--;
        end
        if (pushed) begin
            n_out++;
            for (int i = 0; i <= int'(len); i++) begin
                exp_last.push_back(i == int'(len));
                exp_fin.push_back(fin);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_ni      = 1'b0;
        len_valid_i = 1'b0;
        w_valid_i   = 1'b1;
        w_ready_i   = 1'b1;
        #2;
        check("rst_len_ready", 32'(len_ready_o), 32'd1);
        check("rst_w_valid", 32'(w_valid_o), 32'd0);
        check("rst_w_ready", 32'(w_ready_o), 32'd0);
        check("rst_err", 32'(err_o), 32'd0);
        exp_last.delete();
        exp_fin.delete();
        n_out = 0;
        err_m = 1'b0;
        @(posedge clk);
        #1;
        rst_ni = 1'b1;
    endtask

    task automatic add_burst(input int unsigned len, input bit fin);
        aw_t a;
        a.len = len;
        a.fin = fin;
        aw_todo.push_back(a);
        for (int i = 0; i <= int'(len); i++) w_todo.push_back(fin && (i == int'(len)));
    endtask

    task automatic run(input int unsigned pv, input int unsigned pr);
        int  cyc;
        bit  p, b, dp, dv, dr, wl;
        aw_t a;
        cyc = 0;
        while ((aw_todo.size() > 0 || w_todo.size() > 0) && cyc < 4000) begin
            dp = (aw_todo.size() > 0) && ($urandom_range(99) < pv);
            dv = (w_todo.size() > 0) && ($urandom_range(99) < pv);
            dr = $urandom_range(99) < pr;
            wl = dv ? w_todo[0] : 1'b0;
            if (aw_todo.size() > 0) a = aw_todo[0];
            else begin
                a.len = 0;
                a.fin = 1'b0;
            end
            step(dp, a.len, a.fin, dv, wl, dr, p, b);
            if (p) void'(aw_todo.pop_front());
            if (b) void'(w_todo.pop_front());
            cyc++;
        end
        check("scenario_done", 32'(aw_todo.size() + w_todo.size()), 32'd0);
        aw_todo.delete();
        w_todo.delete();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit p, b;
        @(posedge clk);
        #1;
        do_reset();

        // W ahead of AW stalls, then a len-0 burst lets one last beat through.
        for (int i = 0; i < 5; i++) step(1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b1, p, b);
        step(1'b1, 0, 1'b1, 1'b1, 1'b1, 1'b1, p, b);
        step(1'b0, 0, 1'b0, 1'b1, 1'b1, 1'b1, p, b);
        step(1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b1, p, b);

        // Pieces 3, 3, 1 with one upstream last on beat 10.
        add_burst(3, 1'b0);
        add_burst(3, 1'b0);
        add_burst(1, 1'b1);
        run(80, 80);

        // Fill the two-entry queue with the downstream stalled.
        step(1'b1, 1, 1'b1, 1'b0, 1'b0, 1'b0, p, b);
        step(1'b1, 1, 1'b1, 1'b0, 1'b0, 1'b0, p, b);
        step(1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b0, p, b);
        step(1'b1, 5, 1'b1, 1'b1, 1'b0, 1'b0, p, b);
        step(1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b1, p, b);
        step(1'b0, 0, 1'b0, 1'b1, 1'b1, 1'b1, p, b);
        step(1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, p, b);
        step(1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b1, p, b);
        step(1'b0, 0, 1'b0, 1'b1, 1'b1, 1'b1, p, b);

        // Maximum length piece followed by a single-beat piece.
        add_burst(255, 1'b1);
        add_burst(0, 1'b1);
        run(90, 90);

        // Early upstream last inside a final piece.
        begin
            aw_t a;
            a.len = 3;
            a.fin = 1'b1;
            aw_todo.push_back(a);
            w_todo.push_back(1'b0);
            w_todo.push_back(1'b1);
            w_todo.push_back(1'b0);
            w_todo.push_back(1'b0);
        end
        run(100, 100);
        step(1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, p, b);
        step(1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, p, b);

        // Reset in the middle of a burst, then a fresh burst.
        step(1'b1, 3, 1'b1, 1'b0, 1'b0, 1'b0, p, b);
        step(1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b1, p, b);
        step(1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b1, p, b);
        do_reset();
        step(1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b1, p, b);
        add_burst(1, 1'b1);
        run(100, 100);

        // Random traffic.
        for (int i = 0; i < 24; i++) add_burst($urandom_range(0, 9), 1'($urandom_range(0, 1)));
        run(60, 65);
        step(1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, p, b);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
